div_requester: RTL and testbench

Initiator-side controller for the iterative divider's start/busy/valid/sclr handshake. Buffers operand pairs from an upstream producer in a small FIFO and issues them to the divider one at a time. For each job it waits for completion, captures quotient and flags into a result holding register, and clears the divider for the next job. It sits between the datapath and the divider, so no other block drives the divider's handshake directly.

---
 rtl/div_req_pkg.sv | 23 ++
 rtl/div_req_fifo.sv | 56 +++++
 rtl/div_requester.sv | 153 +++++++++++++++
 tb/tb_div_requester.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_req_pkg.sv
// Shared types for the divider requester: FSM encoding, default sizes and result flags.
// The quotient width is a module parameter, so the result record is completed in div_requester.
package div_req_pkg;

    localparam int DEF_W       = 10;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 1023;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    typedef struct packed {
        logic dvz;
        logic ovf;
        logic tmo;
    } res_flags_t;

endpackage

// File: rtl/div_req_fifo.sv
// Synchronous FIFO holding operand pairs; DEPTH entries of DW bits each.
// Latency: a pushed entry is visible at pop_dat on the cycle after the push edge.
// Backpressure: a push while full is dropped; a pop while empty is ignored.
module div_req_fifo #(
    parameter int DW    = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     sclr,
    input  logic                     push,
    input  logic [DW-1:0]            push_dat,
    input  logic                     pop,
    output logic [DW-1:0]            pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign wr_en   = push & ~full;
    assign rd_en   = pop & ~empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/div_requester.sv
// Feeds buffered operand pairs to the iterative divider and holds each result for a consumer.
// Latency: push to div_start is 2 cycles; divider valid to res_valid is 2 cycles.
// Backpressure: an un-acked result parks the FSM in CAPTURE with the divider left un-cleared.
module div_requester
    import div_req_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   sclr,
    input  logic                   req_push,
    input  logic [W-1:0]           req_a,
    input  logic [W-1:0]           req_b,
    output logic                   req_full,
    output logic [$clog2(DEPTH):0] req_count,
    output logic [W-1:0]           div_a,
    output logic [W-1:0]           div_b,
    output logic                   div_start,
    output logic                   div_sclr,
    input  logic                   div_busy,
    input  logic                   div_valid,
    input  logic [W-1:0]           div_q,
    input  logic                   div_dvz,
    input  logic                   div_ovf,
    output logic                   res_valid,
    output logic [W-1:0]           res_q,
    output logic                   res_dvz,
    output logic                   res_ovf,
    output logic                   res_tmo,
    input  logic                   res_ack
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic [W-1:0] q;
        res_flags_t   flags;
    } res_t;

    state_t         state;
    state_t         state_nxt;
    logic           fifo_pop;
    logic           fifo_empty;
    logic [2*W-1:0] fifo_dat;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [TW-1:0]  tmo_cnt;
    logic           tmo_hit;
    logic           tmo_flag;
    logic           res_load;
    res_t           res_r;
    logic           busy_unused;

    // The divider's busy is purely informational here.
    assign busy_unused = div_busy;

    div_req_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .sclr     (sclr),
        .push     (req_push),
        .push_dat ({req_a, req_b}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (req_full),
        .empty    (fifo_empty),
        .count    (req_count)
    );

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (sclr) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (!fifo_empty) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = ST_WAIT;
            ST_WAIT:    if (div_valid || tmo_hit) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (!res_valid || res_ack) state_nxt = ST_CLEAR;
            ST_CLEAR:   state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop  = 1'b0;
        div_start = 1'b0;
        res_load  = 1'b0;
        div_sclr  = sclr;
        case (state)
            ST_IDLE:    fifo_pop  = ~fifo_empty;
            ST_ISSUE:   div_start = 1'b1;
            ST_CAPTURE: res_load  = ~res_valid | res_ack;
            ST_CLEAR:   div_sclr  = 1'b1;
            default:    ;
        endcase
    end

    // Operands stay put from ISSUE through CLEAR; only the IDLE pop reloads them.
    always_ff @(posedge clk) begin
        if (sclr) begin
            op_a <= '0;
            op_b <= '0;
        end else if (fifo_pop) begin
            {op_a, op_b} <= fifo_dat;
        end
    end

    assign div_a = op_a;
    assign div_b = op_b;

    // tmo_flag tracks the WAIT exit reason; a valid on the final WAIT cycle wins.
    always_ff @(posedge clk) begin
        if (sclr) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (state == ST_ISSUE)     tmo_cnt <= '0;
            else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + TW'(1);
            if (state == ST_WAIT)      tmo_flag <= ~div_valid & tmo_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            res_r     <= '0;
            res_valid <= 1'b0;
        end else if (res_load) begin
            res_r.q         <= tmo_flag ? '0 : div_q;
            res_r.flags.dvz <= ~tmo_flag & div_dvz;
            res_r.flags.ovf <= ~tmo_flag & div_ovf;
            res_r.flags.tmo <= tmo_flag;
            res_valid       <= 1'b1;
        end else if (res_ack && res_valid) begin
            res_valid <= 1'b0;
        end
    end

    assign res_q   = res_r.q;
    assign res_dvz = res_r.flags.dvz;
    assign res_ovf = res_r.flags.ovf;
    assign res_tmo = res_r.flags.tmo;

endmodule

// File: tb/tb_div_requester.sv
// Bench for div_requester: table-driven single jobs, directed FIFO/backpressure/timeout/reset
// sequences, then random traffic scored against a queue of arithmetic quotients.
module tb_div_requester;

    localparam int W       = 10;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 40;
    localparam int LAT     = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         sclr, req_push, req_full;
    logic [W-1:0] req_a, req_b;
    logic [2:0]   req_count;
    logic [W-1:0] div_a, div_b, div_q;
    logic         div_start, div_sclr, div_busy, div_valid, div_dvz, div_ovf;
    logic         res_valid, res_dvz, res_ovf, res_tmo, res_ack;
    logic [W-1:0] res_q;

    div_requester #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .sclr(sclr), .req_push(req_push), .req_a(req_a), .req_b(req_b),
        .req_full(req_full), .req_count(req_count), .div_a(div_a), .div_b(div_b),
        .div_start(div_start), .div_sclr(div_sclr), .div_busy(div_busy), .div_valid(div_valid),
        .div_q(div_q), .div_dvz(div_dvz), .div_ovf(div_ovf), .res_valid(res_valid),
        .res_q(res_q), .res_dvz(res_dvz), .res_ovf(res_ovf), .res_tmo(res_tmo), .res_ack(res_ack)
    );

    // Second instance with a short timeout whose divider never answers.
    logic         t_push, t_full, t_start, t_sclr, t_res_valid, t_res_dvz, t_res_ovf, t_res_tmo, t_ack;
    logic [W-1:0] t_a, t_b, t_div_a, t_div_b, t_res_q;
    logic [2:0]   t_count;

    div_requester #(.W(W), .DEPTH(DEPTH), .TIMEOUT(8)) dut_t (
        .clk(clk), .sclr(sclr), .req_push(t_push), .req_a(t_a), .req_b(t_b),
        .req_full(t_full), .req_count(t_count), .div_a(t_div_a), .div_b(t_div_b),
        .div_start(t_start), .div_sclr(t_sclr), .div_busy(1'b1), .div_valid(1'b0),
        .div_q({W{1'b1}}), .div_dvz(1'b1), .div_ovf(1'b1), .res_valid(t_res_valid),
        .res_q(t_res_q), .res_dvz(t_res_dvz), .res_ovf(t_res_ovf), .res_tmo(t_res_tmo), .res_ack(t_ack)
    );

    // Divider model: latency 'lat' edges after start, valid held until cleared.
    int           lat = LAT;
    logic         stall = 1'b0;
    logic         ovf_force = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '1;
    int           m_cnt = 0;

    always @(posedge clk) begin
        if (div_sclr) begin
            div_busy  <= 1'b0;
            div_valid <= 1'b0;
        end else if (div_start) begin
            div_busy  <= 1'b1;
            div_valid <= 1'b0;
            m_a       <= div_a;
            m_b       <= div_b;
            m_cnt     <= lat;
        end else if (div_busy && !stall) begin
            if (m_cnt <= 1) begin
                div_busy  <= 1'b0;
                div_valid <= 1'b1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign div_q   = (m_b == '0) ? '0 : m_a / m_b;
    assign div_dvz = (m_b == '0);
    assign div_ovf = ovf_force;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ack1();
        res_ack = 1'b1;
        cyc();
        res_ack = 1'b0;
    endtask

    task automatic wait_res(input string name);
        int i = 0;
        while (!res_valid && i < 200) begin
            cyc();
            i++;
        end
        chk({name, "_res_valid"}, res_valid, 1);
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         ovf_in;
        logic [W-1:0] q;
        logic         dvz, ovf;
    } vec_t;

    function automatic vec_t mkv(input int a, input int b, input int oi, input int q, input int dz, input int ov);
        vec_t v;
        v.a = W'(a); v.b = W'(b); v.ovf_in = oi[0];
        v.q = W'(q); v.dvz = dz[0]; v.ovf = ov[0];
        return v;
    endfunction

    // One job from idle/empty: checks issue timing, capture, clear pulse and ack.
    task automatic run_job(input vec_t v, input string nm);
        @(negedge clk);
        ovf_force = v.ovf_in; req_a = v.a; req_b = v.b; req_push = 1'b1;
        cyc();
        req_push = 1'b0;
        chk({nm, "_count1"}, req_count, 1);
        chk({nm, "_no_early_start"}, div_start, 0);
        cyc();
        chk({nm, "_start"}, div_start, 1);
        chk({nm, "_div_a"}, div_a, v.a);
        chk({nm, "_div_b"}, div_b, v.b);
        cyc();
        chk({nm, "_start_1cyc"}, div_start, 0);
        wait_res(nm);
        chk({nm, "_q"}, res_q, v.q);
        chk({nm, "_dvz"}, res_dvz, v.dvz);
        chk({nm, "_ovf"}, res_ovf, v.ovf);
        chk({nm, "_tmo"}, res_tmo, 0);
        chk({nm, "_sclr_pulse"}, div_sclr, 1);
        cyc();
        chk({nm, "_sclr_1cyc"}, div_sclr, 0);
        chk({nm, "_hold_valid"}, res_valid, 1);
        ack1();
        chk({nm, "_acked"}, res_valid, 0);
        ovf_force = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] q;
        logic         dvz;
    } exp_t;

    vec_t         tbl[6];
    logic [W-1:0] pa[6], pb[6];
    exp_t         sb[$];
    exp_t         e;
    int           ns, nst, pushed;

    initial begin
        tbl[0] = mkv(720, 168, 0, 4, 0, 0);
        tbl[1] = mkv(16, 0, 0, 0, 1, 0);
        tbl[2] = mkv(1023, 1, 0, 1023, 0, 0);
        tbl[3] = mkv(5, 7, 0, 0, 0, 0);
        tbl[4] = mkv(1000, 3, 0, 333, 0, 0);
        tbl[5] = mkv(50, 5, 1, 10, 0, 1);

        sclr = 1'b1; req_push = 1'b0; req_a = '0; req_b = '0; res_ack = 1'b0;
        t_push = 1'b0; t_a = '0; t_b = '0; t_ack = 1'b0;
        @(negedge clk);
        chk("rst_div_sclr", div_sclr, 1);
        @(negedge clk);
        sclr = 1'b0;
        cyc();
        chk("rst_div_sclr_off", div_sclr, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_count", req_count, 0);
        chk("rst_full", req_full, 0);
        chk("rst_t_count", t_count, 0);
        chk("rst_t_valid", t_res_valid, 0);

        for (int i = 0; i < 6; i++) run_job(tbl[i], $sformatf("vec%0d", i));

        // FIFO fill while the divider stalls and the consumer withholds ack.
        for (int i = 0; i < 6; i++) begin
            pa[i] = W'(200 + i * 37);
            pb[i] = W'(i + 2);
        end
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                chk("full_before_6th", req_full, 1);
                chk("count_before_6th", req_count, 4);
            end
            req_push = 1'b1; req_a = pa[i]; req_b = pb[i];
        end
        cyc();
        req_push = 1'b0;
        chk("full_after_drop", req_full, 1);
        chk("count_after_drop", req_count, 4);
        stall = 1'b0;
        wait_res("bp0");
        chk("bp0_q", res_q, pa[0] / pb[0]);
        ns = 0; nst = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (div_sclr) ns++;
            if (div_start) nst++;
        end
        chk("bp_no_sclr", ns, 0);
        chk("bp_one_start", nst, 1);
        chk("bp_hold_q", res_q, pa[0] / pb[0]);
        chk("bp_count", req_count, 3);
        ack1();
        chk("bp_reload_valid", res_valid, 1);
        chk("bp_reload_q", res_q, pa[1] / pb[1]);
        chk("bp_reload_sclr", div_sclr, 1);
        ack1();
        for (int j = 2; j < 5; j++) begin
            wait_res($sformatf("order%0d", j));
            chk($sformatf("order%0d_q", j), res_q, pa[j] / pb[j]);
            ack1();
        end
        chk("drain_valid", res_valid, 0);
        repeat (30) cyc();
        chk("dropped_never_ran", res_valid, 0);
        chk("drain_count", req_count, 0);

        // Timeout on the short-timeout instance: result lands 10 edges after start.
        @(negedge clk);
        t_push = 1'b1; t_a = W'(3); t_b = W'(1);
        cyc();
        t_push = 1'b0;
        cyc();
        chk("tmo_start", t_start, 1);
        chk("tmo_div_a", t_div_a, 3);
        chk("tmo_div_b", t_div_b, 1);
        for (int i = 1; i <= 11; i++) begin
            cyc();
            if (i == 10) begin
                chk("tmo_valid", t_res_valid, 1);
                chk("tmo_flag", t_res_tmo, 1);
                chk("tmo_q", t_res_q, 0);
                chk("tmo_dvz", t_res_dvz, 0);
                chk("tmo_ovf", t_res_ovf, 0);
                chk("tmo_sclr", t_sclr, 1);
            end else begin
                chk($sformatf("tmo_sclr_off%0d", i), t_sclr, 0);
                if (i < 10) chk($sformatf("tmo_early%0d", i), t_res_valid, 0);
            end
        end
        t_ack = 1'b1;
        cyc();
        t_ack = 1'b0;
        chk("tmo_acked", t_res_valid, 0);

        // Reset while a job is in WAIT with another still queued.
        @(negedge clk);
        req_push = 1'b1; req_a = W'(99); req_b = W'(9);
        cyc();
        req_a = W'(77); req_b = W'(7);
        cyc();
        req_push = 1'b0;
        ns = 0;
        while (!div_start && ns < 20) begin
            cyc();
            ns++;
        end
        chk("rst_mid_started", div_start, 1);
        repeat (3) cyc();
        sclr = 1'b1;
        #1;
        chk("rst_mid_div_sclr", div_sclr, 1);
        cyc();
        sclr = 1'b0;
        #1;
        chk("rst_mid_sclr_off", div_sclr, 0);
        chk("rst_mid_count", req_count, 0);
        chk("rst_mid_full", req_full, 0);
        chk("rst_mid_div_a", div_a, 0);
        chk("rst_mid_div_b", div_b, 0);
        chk("rst_mid_res_q", res_q, 0);
        chk("rst_mid_flags", {res_valid, res_dvz, res_ovf, res_tmo}, 0);
        repeat (20) cyc();
        chk("rst_mid_quiet", res_valid, 0);
        run_job(tbl[0], "post_rst");

        // Random traffic: producer respects req_full, consumer acks at random.
        pushed = 0;
        for (int c = 0; c < 3000 && (pushed < 60 || sb.size() > 0); c++) begin
            @(negedge clk);
            lat = int'($urandom_range(1, 12));
            res_ack = 1'($urandom_range(0, 1));
            if (res_valid && res_ack) begin
                if (sb.size() == 0) begin
                    chk("rand_spurious", res_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rand_q", res_q, e.q);
                    chk("rand_dvz", res_dvz, e.dvz);
                    chk("rand_ovf", res_ovf, 0);
                    chk("rand_tmo", res_tmo, 0);
                end
            end
            if (pushed < 60 && !req_full && $urandom_range(0, 2) == 0) begin
                req_push = 1'b1;
                req_a = W'($urandom_range(0, 1023));
                req_b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 1023));
                e.dvz = (req_b == '0);
                e.q = e.dvz ? '0 : req_a / req_b;
                sb.push_back(e);
                pushed++;
            end else begin
                req_push = 1'b0;
            end
        end
        req_push = 1'b0;
        res_ack = 1'b0;
        chk("rand_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
